io_ram_bridge: RTL and testbench

Consumes the SPI data client's one-cycle memory command strobes (`io_state`/`io_addr`/`io_wdata`) and executes them as 16-bit word accesses on the shared RAM controller port. Accesses are issued only inside the I/O window of the 4-phase `bus_cycle` so the CPU slot is never disturbed. It returns read data and an `io_ack` pulse to the SPI client, and buffers up to two pending commands.

---
 rtl/io_bridge_pkg.sv | 29 ++
 rtl/io_cmd_fifo.sv | 53 +++++
 rtl/io_ram_bridge.sv | 190 +++++++++++++++++++
 tb/tb_io_ram_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared encodings, FSM state type and command layout for the SPI-to-RAM I/O bridge.
package io_bridge_pkg;

    localparam logic [2:0] IO_IDLE  = 3'b001;
    localparam logic [2:0] IO_READ  = 3'b010;
    localparam logic [2:0] IO_WRITE = 3'b011;
    localparam logic [2:0] IO_FLUSH = 3'b101;

    localparam int DEFAULT_ADDR_W  = 23;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bridge_state_t;

    typedef struct packed {
        logic                      we;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [15:0]               wdata;
    } io_cmd_t;

    // Bus phases 1 and 2 are the I/O window; 0 and 3 belong to the CPU.
    function automatic logic in_io_window(input logic [1:0] bc);
        return (bc == 2'd1) || (bc == 2'd2);
    endfunction

endpackage

// File: rtl/io_cmd_fifo.sv
// Two-entry command FIFO with flush; a push into a full FIFO is accepted when a pop happens on the same edge.
module io_cmd_fifo #(
    parameter int W = 40
) (
    input  logic         clk_8,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; flush wins over any push/pop on the same edge.
    always_ff @(posedge clk_8) begin
        if (reset || flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk_8) begin
        if (push_ok_s && !reset && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/io_ram_bridge.sv
// Executes buffered SPI memory commands as 16-bit RAM accesses inside the bus I/O window.
// Optional access timeout is enabled by defining IO_BRIDGE_TIMEOUT_EN.
module io_ram_bridge
    import io_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_8,
    input  logic              reset,
    input  logic [1:0]        bus_cycle,
    input  logic [2:0]        io_state,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [15:0]       io_wdata,
    output logic [15:0]       io_rdata,
    output logic              io_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    localparam int CMD_W = 1 + ADDR_W + 16;

    bridge_state_t     state_r;
    bridge_state_t     state_next_s;
    logic              start_s;
    logic              complete_s;
    logic              timed_out_s;
    logic              tmo_hit_s;
    logic              cmd_push_s;
    logic              cmd_flush_s;
    logic              flush_hit_s;
    logic              flushed_r;
    logic [CMD_W-1:0]  cmd_in_s;
    logic [CMD_W-1:0]  head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [15:0]       io_rdata_r;
    logic              io_ack_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic              overrun_r;

    assign cmd_push_s  = (io_state == IO_READ) || (io_state == IO_WRITE);
    assign cmd_flush_s = (io_state == IO_FLUSH);
    assign cmd_in_s    = {(io_state == IO_WRITE), io_addr, io_wdata};
    // A flush arriving on the completion edge itself must also suppress the result.
    assign flush_hit_s = flushed_r || cmd_flush_s;

    io_cmd_fifo #(.W(CMD_W)) u_fifo (
        .clk_8 (clk_8),
        .reset (reset),
        .push  (cmd_push_s),
        .pop   (start_s),
        .flush (cmd_flush_s),
        .din   (cmd_in_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_r;

    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
    assign timeout   = timeout_r;

    // Counts ACCESS cycles spent waiting for mem_ready; sticky flag on expiry.
    always_ff @(posedge clk_8) begin
        if (reset) begin
            tmo_cnt_r <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (start_s) begin
                tmo_cnt_r <= '0;
            end else if (state_r == ACCESS && !mem_ready) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (timed_out_s) begin
                timeout_r <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next-state and access control decode.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        complete_s   = 1'b0;
        timed_out_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && in_io_window(bus_cycle) && !cmd_flush_s) begin
                    start_s      = 1'b1;
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    complete_s   = 1'b1;
                    state_next_s = DONE;
                end else if (tmo_hit_s) begin
                    timed_out_s  = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_8) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory port, SPI-side results and sticky overrun flag.
    always_ff @(posedge clk_8) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 16'h0000;
            io_rdata_r  <= 16'h0000;
            io_ack_r    <= 1'b0;
            flushed_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            io_ack_r <= (state_r == DONE) && !flush_hit_s;
            if (start_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= head_s[CMD_W-1];
                mem_addr_r  <= head_s[CMD_W-2 -: ADDR_W];
                mem_wdata_r <= head_s[15:0];
            end else if (complete_s || timed_out_s) begin
                mem_req_r <= 1'b0;
            end
            if (start_s) begin
                flushed_r <= 1'b0;
            end else if (cmd_flush_s && state_r != IDLE) begin
                flushed_r <= 1'b1;
            end
            if (complete_s && !mem_we_r && !flush_hit_s) begin
                io_rdata_r <= mem_rdata;
            end else if (timed_out_s && !mem_we_r && !flush_hit_s) begin
                io_rdata_r <= 16'hFFFF;
            end
            if (cmd_push_s && fifo_full_s && !start_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign io_rdata  = io_rdata_r;
    assign io_ack    = io_ack_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign overrun   = overrun_r;
    assign busy      = !fifo_empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_io_ram_bridge.sv
// Randomized and directed bench for io_ram_bridge against a queue-based transaction model.
module tb_io_ram_bridge;
    import io_bridge_pkg::*;

    localparam int TMO = 255;

    logic        clk_8 = 1'b0;
    logic        reset;
    logic [1:0]  bus_cycle;
    logic [2:0]  io_state;
    logic [22:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ack;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        overrun;
    logic        timeout;

    io_ram_bridge #(.ADDR_W(23), .TIMEOUT(TMO)) dut (
        .clk_8     (clk_8),
        .reset     (reset),
        .bus_cycle (bus_cycle),
        .io_state  (io_state),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk_8 = ~clk_8;

    // Reference model: pending queue plus a description of the access in progress.
    io_cmd_t     q[$];
    io_cmd_t     cur;
    int          phase;      // 0 waiting, 1 on the memory port, 2 completion pending
    bit          m_flushed;
    logic        m_req, m_we, m_ack, m_ovr, m_tmo;
    logic [22:0] m_addr;
    logic [15:0] m_wdata, m_rdata;
    int          acc_cnt, delay, next_delay;
    bit          rand_dly, rd_rand;
    logic [15:0] rd_val;
    logic [1:0]  bc_cnt;
    logic        prev_req;
    int          dut_acks;
    int          n_vec, n_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase = 0; m_flushed = 0;
        m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_ack = 0; m_ovr = 0; m_tmo = 0; acc_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst, input logic [2:0] st, input logic [22:0] a, input logic [15:0] d);
        logic [1:0] bc_s;
        bit         flush;
        io_cmd_t    c;
        bc_s      = bc_cnt;
        reset     = rst;
        io_state  = st;
        io_addr   = a;
        io_wdata  = d;
        bus_cycle = bc_s;
        mem_ready = (phase == 1) && (acc_cnt >= delay);
        mem_rdata = rd_rand ? 16'($urandom) : rd_val;
        if (rst) begin
            model_reset();
        end else begin
            flush = (st == IO_FLUSH);
            m_ack = 0;
            if (phase == 0) begin
                if (q.size() > 0 && (bc_s == 2'd1 || bc_s == 2'd2) && !flush) begin
                    cur = q.pop_front();
                    m_req = 1; m_we = cur.we; m_addr = cur.addr; m_wdata = cur.wdata;
                    phase = 1; acc_cnt = 0; m_flushed = 0;
                    delay = rand_dly ? int'($urandom_range(0, 4)) : next_delay;
                end
            end else if (phase == 1) begin
                if (flush) m_flushed = 1;
                if (mem_ready) begin
                    m_req = 0;
                    if (!cur.we && !m_flushed) m_rdata = mem_rdata;
                    phase = 2;
`ifdef IO_BRIDGE_TIMEOUT_EN
                end else if (acc_cnt == TMO - 1) begin
                    m_req = 0; m_tmo = 1;
                    if (!cur.we && !m_flushed) m_rdata = 16'hFFFF;
                    phase = 2;
`endif
                end else begin
                    acc_cnt++;
                end
            end else begin
                m_ack = !(m_flushed || flush);
                phase = 0;
            end
            if (flush) q.delete();
            if (st == IO_READ || st == IO_WRITE) begin
                c.we = (st == IO_WRITE); c.addr = a; c.wdata = d;
                if (q.size() < 2) q.push_back(c);
                else m_ovr = 1;
            end
        end
        @(posedge clk_8);
        #1;
        check_val("mem_req", mem_req, m_req);
        check_val("io_ack", io_ack, m_ack);
        check_val("busy", busy, (q.size() > 0) || (phase != 0));
        check_val("overrun", overrun, m_ovr);
        check_val("timeout", timeout, m_tmo);
        check_val("io_rdata", io_rdata, m_rdata);
        check_val("mem_we", mem_we, m_we);
        check_val("mem_addr", mem_addr, m_addr);
        check_val("mem_wdata", mem_wdata, m_wdata);
        if (mem_req && !prev_req) check_val("req_window", in_io_window(bc_s), 1'b1);
        prev_req = mem_req;
        if (io_ack) dut_acks++;
        bc_cnt = bc_cnt + 2'd1;
        @(negedge clk_8);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, IO_IDLE, 23'h0, 16'h0);
    endtask

    task automatic wait_access();
        for (int i = 0; i < 16 && phase != 1; i++) step(1'b0, IO_IDLE, 23'h0, 16'h0);
        check_val("reach_access", mem_req, 1'b1);
    endtask

    initial begin
        int          base;
        logic [15:0] saved;
        logic [2:0]  st;
        logic [2:0]  odd_codes [4];
        bit          last_cmd;
        n_vec = 0; n_err = 0; dut_acks = 0; prev_req = 0;
        bc_cnt = 2'd0; rand_dly = 0; rd_rand = 0; next_delay = 2; rd_val = 16'h0;
        reset = 1; io_state = IO_IDLE; io_addr = '0; io_wdata = '0;
        bus_cycle = '0; mem_rdata = '0; mem_ready = 0;
        model_reset();
        @(negedge clk_8);
        step(1'b1, IO_IDLE, 23'h0, 16'h0);
        step(1'b1, IO_IDLE, 23'h0, 16'h0);
        check_val("rst_rdata", io_rdata, 16'h0000);
        check_val("rst_busy", busy, 1'b0);

        // Read returning BEEF, ready two cycles after request.
        rd_val = 16'hBEEF; next_delay = 2; base = dut_acks;
        step(1'b0, IO_READ, 23'h001000, 16'h0);
        idle_n(12);
        check_val("beef_rdata", io_rdata, 16'hBEEF);
        check_val("beef_acks", dut_acks - base, 1);

        // Write to top address pushed during pre-CPU phase.
        while (bc_cnt != 2'd3) step(1'b0, IO_IDLE, 23'h0, 16'h0);
        step(1'b0, IO_WRITE, 23'h7FFFFF, 16'h1234);
        wait_access();
        check_val("wr_we", mem_we, 1'b1);
        check_val("wr_addr", mem_addr, 23'h7FFFFF);
        check_val("wr_wdata", mem_wdata, 16'h1234);
        idle_n(8);

        // Three writes under a stalled controller, fourth overflows.
        next_delay = 12; base = dut_acks;
        step(1'b0, IO_WRITE, 23'h000010, 16'h1111);
        wait_access();
        step(1'b0, IO_WRITE, 23'h000011, 16'h2222);
        step(1'b0, IO_IDLE, 23'h0, 16'h0);
        step(1'b0, IO_WRITE, 23'h000012, 16'h3333);
        step(1'b0, IO_IDLE, 23'h0, 16'h0);
        check_val("stall_busy", busy, 1'b1);
        step(1'b0, IO_WRITE, 23'h000013, 16'h4444);
        check_val("stall_overrun", overrun, 1'b1);
        idle_n(60);
        check_val("stall_acks", dut_acks - base, 3);

        // Flush during a read access with one entry queued.
        next_delay = 6; rd_val = 16'hA5A5; base = dut_acks; saved = m_rdata;
        step(1'b0, IO_READ, 23'h000200, 16'h0);
        wait_access();
        step(1'b0, IO_WRITE, 23'h000201, 16'h5555);
        step(1'b0, IO_FLUSH, 23'h0, 16'h0);
        idle_n(20);
        check_val("flush_acks", dut_acks - base, 0);
        check_val("flush_rdata", io_rdata, saved);
        check_val("flush_busy", busy, 1'b0);

        // Reset in the middle of an access.
        next_delay = 10;
        step(1'b0, IO_READ, 23'h000300, 16'h0);
        wait_access();
        step(1'b1, IO_IDLE, 23'h0, 16'h0);
        check_val("rstmid_req", mem_req, 1'b0);
        check_val("rstmid_ack", io_ack, 1'b0);
        check_val("rstmid_busy", busy, 1'b0);
        check_val("rstmid_ovr", overrun, 1'b0);
        check_val("rstmid_tmo", timeout, 1'b0);
        check_val("rstmid_rdata", io_rdata, 16'h0000);

`ifdef IO_BRIDGE_TIMEOUT_EN
        // Read that never completes on the memory side.
        next_delay = 1 << 30; base = dut_acks;
        step(1'b0, IO_READ, 23'h000400, 16'h0);
        wait_access();
        idle_n(TMO + 10);
        check_val("tmo_flag", timeout, 1'b1);
        check_val("tmo_rdata", io_rdata, 16'hFFFF);
        check_val("tmo_acks", dut_acks - base, 1);
        step(1'b1, IO_IDLE, 23'h0, 16'h0);
`endif

        // Randomized traffic with random controller latency and occasional resets.
        odd_codes[0] = 3'b000; odd_codes[1] = 3'b100;
        odd_codes[2] = 3'b110; odd_codes[3] = 3'b111;
        rand_dly = 1; rd_rand = 1; last_cmd = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (last_cmd) st = IO_IDLE;
            else if (r < 55) st = IO_IDLE;
            else if (r < 72) st = IO_READ;
            else if (r < 89) st = IO_WRITE;
            else if (r < 94) st = IO_FLUSH;
            else st = odd_codes[$urandom_range(0, 3)];
            last_cmd = (st != IO_IDLE);
            step(($urandom_range(0, 399) == 0), st,
                 ($urandom_range(0, 7) == 0) ? 23'h7FFFFF : 23'($urandom),
                 16'($urandom));
        end
        idle_n(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
